fft_top_mul_rnd_sat: RTL
========================

// Module: fft_top_mul_rnd_sat
// PURPOSE
// Parametrised pipelined signed x unsigned multiplier for FFT twiddle and
// window scaling. Computes full-precision product, drops SHIFT LSBs with
// run-time rounding mode, saturates to OUT_WIDTH and tags each sample with a
// valid bit. Counts saturation events for host monitoring.
// PARAMETERS
// A_WIDTH    24  width of signed operand din0
// B_WIDTH    15  width of unsigned operand din1
// OUT_WIDTH  24  width of signed result dout
// SHIFT      14  LSBs discarded after multiply; 0 <= SHIFT < A_WIDTH+B_WIDTH
// STAGES     3   pipeline latency in ce-qualified cycles; minimum 3
// CNT_WIDTH  16  width of saturation event counter
// PORTS
// clk       in   1          clock
// reset     in   1          synchronous active-high reset
// ce        in   1          clock enable; low freezes entire pipeline
// din0      in   A_WIDTH    signed multiplicand
// din1      in   B_WIDTH    unsigned multiplier
// din_vld   in   1          din0/din1/rnd_mode valid
// rnd_mode  in   2          0 truncate (floor), 1 round half up, 2 convergent, 3 = 0
// clr_cnt   in   1          clear ovf_cnt; not gated by ce
// dout      out  OUT_WIDTH  rounded, saturated signed result
// dout_vld  out  1          dout valid
// ovf       out  1          dout was saturated (qualified by dout_vld)
// ovf_cnt   out  CNT_WIDTH  saturating count of ovf events
// BEHAVIOUR
// - One clock, clk. reset is synchronous and active-high. It clears all valid
//   bits, data registers, dout, ovf and ovf_cnt to 0. Reset overrides ce.
// - Pipeline: stage 1 registers din0, din1, rnd_mode and din_vld.
//   Stages 2..STAGES-1 form the product P = $signed(a) * $signed({1'b0,b}),
//   FW = A_WIDTH+B_WIDTH bits signed. Extra stages are retiming registers.
//   Stage STAGES is the registered round/saturate output.
// - All stage registers, including valid bits, load only when ce=1.
//   With ce=0 every output holds its value. Latency is exactly STAGES
//   ce-high cycles.
// - rnd_mode travels with its sample, so a mode change applies per sample.
// - Rounding is computed in FW+1 bits (no internal wrap).
//   F = P[SHIFT-1:0]; H = 2^(SHIFT-1).
//   - trunc:  R = P >>> SHIFT.
//   - half-up: R = (P + H) >>> SHIFT.
//   - convergent: same as half-up, except when F == H exactly; then
//     R = (P >>> SHIFT) rounded to the even value.
//   - SHIFT=0: all modes give R = P.
// - Saturation:
//   - R > 2^(OUT_WIDTH-1)-1  ->  dout = max, ovf = 1.
//   - R < -2^(OUT_WIDTH-1)   ->  dout = min, ovf = 1.
//   - Otherwise dout = R[OUT_WIDTH-1:0] and ovf = 0.
// - Invalid samples still propagate data, but force ovf = 0 and never count.
// - ovf_cnt increments when the output stage loads (ce=1) a sample with
//   dout_vld=1 and ovf=1. It holds at all-ones and does not wrap.
// - clr_cnt=1 sets ovf_cnt to 0. If clr_cnt and an increment occur in the same
//   cycle, ovf_cnt = 1 (the event is not lost).
// - No backpressure: the downstream block must accept every dout_vld cycle.
// TESTING
// 1. Defaults, mode 0: din0=1000, din1=16384, din_vld=1 -> after 3 cycles
//    dout=1000, dout_vld=1, ovf=0.
// 2. Rounding, din1=8192. Results listed as trunc / half-up / convergent:
//    - din0=3  -> 1 / 2 / 2
//    - din0=1  -> 0 / 1 / 0
//    - din0=-1 -> -1 / 0 / 0
// 3. Saturation: din0=8388607, din1=32767 -> dout=8388607, ovf=1.
//    Then din0=-8388608 -> dout=-8388608, ovf=1. ovf_cnt=2.
// 4. Stall: stream 0..9 back-to-back, ce=0 for 5 cycles mid-stream.
//    Outputs frozen during the stall; all 10 results appear in order with no
//    loss or duplicate; dout_vld never pulses while ce=0.
// 5. Reset mid-stream: assert reset with 2 samples in flight -> next cycle
//    dout_vld=0, dout=0, ovf_cnt=0; no in-flight sample ever emerges.
// 6. Counter, CNT_WIDTH=4: 20 consecutive overflows -> ovf_cnt=15 and holds.
//    clr_cnt together with an overflow -> ovf_cnt=1. clr_cnt alone -> 0.

Source files
------------

// File: rtl/fft_top_mul_rnd_sat.sv
// Pipelined signed x unsigned multiplier with run-time rounding mode,
// saturation to OUT_WIDTH and a saturating overflow event counter.
// Pipeline: input register -> STAGES-2 product/retiming registers ->
// registered round/saturate output. A low ce freezes every stage.
module fft_top_mul_rnd_sat #(
  parameter int A_WIDTH   = 24,
  parameter int B_WIDTH   = 15,
  parameter int OUT_WIDTH = 24,
  parameter int SHIFT     = 14,
  parameter int STAGES    = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic [A_WIDTH-1:0]   din0,
  input  logic [B_WIDTH-1:0]   din1,
  input  logic                 din_vld,
  input  logic [1:0]           rnd_mode,
  input  logic                 clr_cnt,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_vld,
  output logic                 ovf,
  output logic [CNT_WIDTH-1:0] ovf_cnt
);

  localparam int FW = A_WIDTH + B_WIDTH;
  localparam int NP = STAGES - 2;

  localparam logic [FW:0] ONE_W = {{FW{1'b0}}, 1'b1};
  localparam logic [FW:0] HALF  = (ONE_W << SHIFT) >> 1;
  localparam logic [FW:0] MASK  = (ONE_W << SHIFT) - ONE_W;

  localparam logic [1:0] MODE_HALF_UP = 2'd1;
  localparam logic [1:0] MODE_CONV    = 2'd2;

  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // Stage 1 registers
  logic [A_WIDTH-1:0] a_q;
  logic [B_WIDTH-1:0] b_q;
  logic [1:0]         mode_q;
  logic               vld_q;

  // Product and retiming registers
  logic signed [FW-1:0] p_q [NP];
  logic [1:0]           pm_q [NP];
  logic                 pv_q [NP];

  logic signed [FW-1:0] a_ext;
  logic signed [FW-1:0] b_ext;

  logic [FW:0]          ext;
  logic [FW:0]          frac;
  logic signed [FW:0]   r_trunc;
  logic signed [FW:0]   r_half;
  logic signed [FW:0]   r;
  logic                 in_range;
  logic [OUT_WIDTH-1:0] sat_dout;
  logic                 sat_ovf;
  logic                 cnt_inc;

  // Stage 1: capture operands, mode and valid together so each sample keeps its own mode
  always_ff @(posedge clk) begin
    // NOTE: data registers are reset as well as valid bits so reset leaves a fully zeroed, deterministic pipeline.
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      vld_q  <= 1'b0;
    end else if (ce) begin
      // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
      a_q    <= din0;
      b_q    <= din1;
      mode_q <= rnd_mode;
      vld_q  <= din_vld;
    end
  end

  // Both operands extended to FW bits; the exact product fits, so the FW-bit product is exact
  assign a_ext = {{B_WIDTH{a_q[A_WIDTH-1]}}, a_q};
  assign b_ext = {{A_WIDTH{1'b0}}, b_q};

  // Stages 2..STAGES-1: form the product, then shift it through retiming registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NP; k++) begin
        p_q[k]  <= '0;
        pm_q[k] <= '0;
        pv_q[k] <= 1'b0;
      end
    end else if (ce) begin
      p_q[0]  <= a_ext * b_ext;
      pm_q[0] <= mode_q;
      pv_q[0] <= vld_q;
      for (int k = 1; k < NP; k++) begin
        p_q[k]  <= p_q[k-1];
        pm_q[k] <= pm_q[k-1];
        pv_q[k] <= pv_q[k-1];
      end
    end
  end

  // Round in FW+1 bits so adding the half LSB can never wrap
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    r       = '0;
    ext     = {p_q[NP-1][FW-1], p_q[NP-1]};
    frac    = ext & MASK;
    r_trunc = $signed(ext) >>> SHIFT;
    r_half  = $signed(ext + HALF) >>> SHIFT;
    case (pm_q[NP-1])
      MODE_HALF_UP: r = r_half;
      MODE_CONV: begin
        // Exact tie: pick the even neighbour of the floor value
        if (SHIFT != 0 && frac == HALF) r = r_trunc + {{FW{1'b0}}, r_trunc[0]};
        else                            r = r_half;
      end
      default: r = r_trunc;
    endcase
  end

  // Saturate: the value fits when all bits above the output sign bit match it
  always_comb begin
    in_range = (&r[FW:OUT_WIDTH-1]) | ~(|r[FW:OUT_WIDTH-1]);
    sat_dout = r[OUT_WIDTH-1:0];
    if (!in_range) sat_dout = r[FW] ? OUT_MIN : OUT_MAX;
    sat_ovf  = ~in_range & pv_q[NP-1];
  end

  assign cnt_inc = ce & sat_ovf;

  // Output stage: registered result, valid and overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
    end else if (ce) begin
      dout     <= sat_dout;
      dout_vld <= pv_q[NP-1];
      ovf      <= sat_ovf;
    end
  end

  // Overflow event counter: saturates at all-ones, clear is not gated by ce and keeps a coincident event
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_cnt <= '0;
    end else if (clr_cnt) begin
      ovf_cnt <= cnt_inc ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : '0;
    end else if (cnt_inc && !(&ovf_cnt)) begin
      ovf_cnt <= ovf_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule
